// File: rtl/tour_cmd_seq_if.sv
// Command bus between the tour sequencer, the UART wrapper and the command
// processor. The sequencer is the master: it issues cmd/cmd_rdy and returns
// the UART accept strobe. The slave view is the surrounding environment.
interface tour_cmd_seq_if;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;

  modport master (
    input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output clr_cmd_rdy_UART, cmd, cmd_rdy
  );

  modport slave (
    output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  clr_cmd_rdy_UART, cmd, cmd_rdy
  );
endinterface

// File: rtl/tour_cmd_seq.sv
// Tour command sequencer: replays the 24 solved knight moves as a vertical
// then a horizontal movement command each; passes UART commands through
// while no tour is running.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | UART commands pass straight through
// VERT      | vertical leg of move mv_indx offered (zero move aborts)
// VERT_HOLD | vertical leg accepted, waiting for its response
// HORZ      | horizontal leg of move mv_indx offered
// HORZ_HOLD | horizontal leg accepted, waiting for its response
module tour_cmd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  output logic        tour_active,
  output logic        tour_done,
  output logic        tour_err,
  tour_cmd_seq_if.master bus
);

  typedef enum logic [2:0] {IDLE, VERT, VERT_HOLD, HORZ, HORZ_HOLD} state_t;

  localparam logic [4:0] LAST_IDX = 5'd23;
  localparam logic [3:0] OP_MOVE  = 4'h2;
  localparam logic [3:0] OP_FANF  = 4'h3;
  localparam logic [7:0] HD_NORTH = 8'h00;
  localparam logic [7:0] HD_SOUTH = 8'h7F;
  localparam logic [7:0] HD_EAST  = 8'hBF;
  localparam logic [7:0] HD_WEST  = 8'h3F;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] vert_cmd, horz_cmd;

  // Decode the lowest set move bit into its two legs; casez order gives priority.
  always_comb begin
    vert_cmd = 16'h0000;
    horz_cmd = 16'h0000;
    casez (move)
      8'b???????1: begin vert_cmd = {OP_MOVE, HD_NORTH, 4'd2}; horz_cmd = {OP_FANF, HD_WEST, 4'd1}; end
      8'b??????10: begin vert_cmd = {OP_MOVE, HD_NORTH, 4'd2}; horz_cmd = {OP_FANF, HD_EAST, 4'd1}; end
      8'b?????100: begin vert_cmd = {OP_MOVE, HD_NORTH, 4'd1}; horz_cmd = {OP_FANF, HD_WEST, 4'd2}; end
      8'b????1000: begin vert_cmd = {OP_MOVE, HD_SOUTH, 4'd1}; horz_cmd = {OP_FANF, HD_WEST, 4'd2}; end
      8'b???10000: begin vert_cmd = {OP_MOVE, HD_SOUTH, 4'd2}; horz_cmd = {OP_FANF, HD_WEST, 4'd1}; end
      8'b??100000: begin vert_cmd = {OP_MOVE, HD_SOUTH, 4'd2}; horz_cmd = {OP_FANF, HD_EAST, 4'd1}; end
      8'b?1000000: begin vert_cmd = {OP_MOVE, HD_SOUTH, 4'd1}; horz_cmd = {OP_FANF, HD_EAST, 4'd2}; end
      8'b10000000: begin vert_cmd = {OP_MOVE, HD_NORTH, 4'd1}; horz_cmd = {OP_FANF, HD_EAST, 4'd2}; end
      default:     begin vert_cmd = 16'h0000; horz_cmd = 16'h0000; end
    endcase
  end

  // State, move index and the two status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state plus the command mux; UART path is the default view.
  always_comb begin
    state_d              = state_q;
    idx_d                = idx_q;
    done_d               = 1'b0;
    err_d                = 1'b0;
    bus.cmd              = bus.cmd_UART;
    bus.cmd_rdy          = bus.cmd_rdy_UART;
    bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
    case (state_q)
      IDLE: begin
        if (start_tour) begin
          idx_d   = 5'd0;
          state_d = VERT;
        end
      end
      VERT: begin
        bus.clr_cmd_rdy_UART = 1'b0;
        bus.cmd              = vert_cmd;
        if (move == 8'h00) begin
          // Solver handed back an empty move: abort without issuing anything.
          bus.cmd_rdy = 1'b0;
          err_d       = 1'b1;
          state_d     = IDLE;
        end else begin
          bus.cmd_rdy = 1'b1;
          if (bus.clr_cmd_rdy) state_d = VERT_HOLD;
        end
      end
      VERT_HOLD: begin
        bus.clr_cmd_rdy_UART = 1'b0;
        bus.cmd              = vert_cmd;
        bus.cmd_rdy          = 1'b0;
        if (bus.send_resp) state_d = HORZ;
      end
      HORZ: begin
        bus.clr_cmd_rdy_UART = 1'b0;
        bus.cmd              = horz_cmd;
        bus.cmd_rdy          = 1'b1;
        if (bus.clr_cmd_rdy) state_d = HORZ_HOLD;
      end
      HORZ_HOLD: begin
        bus.clr_cmd_rdy_UART = 1'b0;
        bus.cmd              = horz_cmd;
        bus.cmd_rdy          = 1'b0;
        if (bus.send_resp) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = VERT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tour_active = (state_q != IDLE);
  assign mv_indx     = idx_q;
  assign tour_done   = done_q;
  assign tour_err    = err_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
`timescale 1ns/1ps
module tb_tour_cmd_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_tour = 1'b0;
  logic [7:0] move;
  logic [4:0] mv_indx;
  logic       tour_active, tour_done, tour_err;

  tour_cmd_seq_if bus();

  tour_cmd_seq dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
    .mv_indx(mv_indx), .tour_active(tour_active), .tour_done(tour_done),
    .tour_err(tour_err), .bus(bus)
  );

  always #10 clk = ~clk;

  // Solver readout model: combinational lookup by index.
  logic [7:0] tour_mv [32];
  assign move = tour_mv[mv_indx];

  typedef struct { logic [15:0] cmd; logic [4:0] idx; } exp_t;
  typedef struct { logic [7:0] mv; logic [15:0] vcmd; logic [15:0] hcmd; } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[11];

  int dx_t[8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
  int dy_t[8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};

  int n_cmp = 0, n_bad = 0;
  int n_acc = 0, n_done = 0, n_err = 0;
  int px = 0, py = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] v_cmd(int dy);
    int a;
    a = (dy < 0) ? -dy : dy;
    return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, a[3:0]};
  endfunction

  function automatic logic [15:0] h_cmd(int dx);
    int a;
    a = (dx < 0) ? -dx : dx;
    return {4'h3, (dx > 0) ? 8'hBF : 8'h3F, a[3:0]};
  endfunction

  task automatic push_move(int idx, int b);
    exp_t e;
    e.idx = idx[4:0];
    e.cmd = v_cmd(dy_t[b]); sb_q.push_back(e);
    e.cmd = h_cmd(dx_t[b]); sb_q.push_back(e);
  endtask

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start_tour = 1'b1; cyc(1); start_tour = 1'b0;
  endtask

  task automatic accept(int acc);
    int n = 0;
    while (!bus.cmd_rdy && n < 60) begin cyc(1); n++; end
    if (!bus.cmd_rdy) chk("cmd_rdy_timeout", 32'(bus.cmd_rdy), 32'd1);
    else begin
      cyc(acc);
      bus.clr_cmd_rdy = 1'b1; cyc(1); bus.clr_cmd_rdy = 1'b0;
      chk("rdy_drop_after_accept", 32'(bus.cmd_rdy), 32'd0);
    end
  endtask

  task automatic respond(int rsp);
    cyc(rsp);
    bus.send_resp = 1'b1; cyc(1); bus.send_resp = 1'b0;
  endtask

  task automatic wait_err();
    int n = 0;
    while (!tour_err && n < 20) begin cyc(1); n++; end
    chk("tour_err_seen", 32'(tour_err), 32'd1);
  endtask

  // Scoreboard monitor: every accepted tour command pops one expectation.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (tour_done) n_done++;
      if (tour_err) n_err++;
      if (tour_active && bus.cmd_rdy && bus.clr_cmd_rdy) begin
        n_acc++;
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_unexpected_cmd: got %0h expected none", bus.cmd);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_cmd", 32'(bus.cmd), 32'(mon_e.cmd));
          chk("sb_idx", 32'(mv_indx), 32'(mon_e.idx));
        end
        case (bus.cmd[11:4])
          8'h00: py += int'(bus.cmd[3:0]);
          8'h7F: py -= int'(bus.cmd[3:0]);
          8'hBF: px += int'(bus.cmd[3:0]);
          8'h3F: px -= int'(bus.cmd[3:0]);
          default: ;
        endcase
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    int acc0, done0, err0, ex, ey, b;
    exp_t e;
    for (int i = 0; i < 32; i++) tour_mv[i] = 8'h00;
    vecs[0]  = '{8'h01, 16'h2002, 16'h33F1};
    vecs[1]  = '{8'h02, 16'h2002, 16'h3BF1};
    vecs[2]  = '{8'h04, 16'h2001, 16'h33F2};
    vecs[3]  = '{8'h08, 16'h27F1, 16'h33F2};
    vecs[4]  = '{8'h10, 16'h27F2, 16'h33F1};
    vecs[5]  = '{8'h20, 16'h27F2, 16'h3BF1};
    vecs[6]  = '{8'h40, 16'h27F1, 16'h3BF2};
    vecs[7]  = '{8'h80, 16'h2001, 16'h3BF2};
    vecs[8]  = '{8'hC4, 16'h2001, 16'h33F2};
    vecs[9]  = '{8'hA0, 16'h27F2, 16'h3BF1};
    vecs[10] = '{8'hFF, 16'h2002, 16'h33F1};

    // Reset defaults: UART path visible while in reset.
    bus.cmd_UART = 16'h2003; bus.cmd_rdy_UART = 1'b1;
    bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
    #5;
    chk("rst_cmd", 32'(bus.cmd), 32'h2003);
    chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
    chk("rst_active", 32'(tour_active), 32'd0);
    chk("rst_done", 32'(tour_done), 32'd0);
    chk("rst_err", 32'(tour_err), 32'd0);
    chk("rst_idx", 32'(mv_indx), 32'd0);
    bus.clr_cmd_rdy = 1'b1; #1;
    chk("rst_clr_uart_hi", 32'(bus.clr_cmd_rdy_UART), 32'd1);
    bus.clr_cmd_rdy = 1'b0; #1;
    chk("rst_clr_uart_lo", 32'(bus.clr_cmd_rdy_UART), 32'd0);
    bus.cmd_rdy_UART = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    cyc(2);

    // Table-driven decode: one move, then a zero move ends the tour.
    for (int v = 0; v < 11; v++) begin
      tour_mv[0] = vecs[v].mv; tour_mv[1] = 8'h00;
      e.idx = 5'd0;
      e.cmd = vecs[v].vcmd; sb_q.push_back(e);
      e.cmd = vecs[v].hcmd; sb_q.push_back(e);
      pulse_start();
      chk("vec_vert_rdy", 32'(bus.cmd_rdy), 32'd1);
      chk("vec_vert_cmd", 32'(bus.cmd), 32'(vecs[v].vcmd));
      accept(1); respond(2);
      chk("vec_horz_rdy", 32'(bus.cmd_rdy), 32'd1);
      chk("vec_horz_cmd", 32'(bus.cmd), 32'(vecs[v].hcmd));
      accept(2); respond(1);
      wait_err();
      chk("vec_end_active", 32'(tour_active), 32'd0);
      chk("vec_end_idx", 32'(mv_indx), 32'd1);
      cyc(2);
    end
    chk("vec_sb_empty", 32'(sb_q.size()), 32'd0);

    // Ignored events, then reset in HORZ_HOLD at index 10.
    tour_mv[0] = 8'h02; push_move(0, 1);
    for (int i = 1; i <= 10; i++) begin
      b = $urandom_range(0, 7);
      tour_mv[i] = 8'h01 << b; push_move(i, b);
    end
    pulse_start();
    bus.send_resp = 1'b1; cyc(1); bus.send_resp = 1'b0;
    chk("ign_resp_rdy", 32'(bus.cmd_rdy), 32'd1);
    chk("ign_resp_cmd", 32'(bus.cmd), 32'h2002);
    start_tour = 1'b1; bus.cmd_UART = 16'hFFFF; bus.cmd_rdy_UART = 1'b1;
    cyc(1); start_tour = 1'b0;
    chk("ign_start_cmd", 32'(bus.cmd), 32'h2002);
    chk("ign_start_idx", 32'(mv_indx), 32'd0);
    bus.clr_cmd_rdy = 1'b1; bus.send_resp = 1'b1; #1;
    chk("ign_clr_uart_held", 32'(bus.clr_cmd_rdy_UART), 32'd0);
    cyc(1); bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
    chk("ign_hold_rdy", 32'(bus.cmd_rdy), 32'd0);
    chk("ign_hold_cmd", 32'(bus.cmd), 32'h2002);
    cyc(3);
    bus.clr_cmd_rdy = 1'b1; cyc(1); bus.clr_cmd_rdy = 1'b0;
    chk("ign_hold_still", 32'(bus.cmd_rdy), 32'd0);
    respond(0);
    chk("ign_horz_rdy", 32'(bus.cmd_rdy), 32'd1);
    chk("ign_horz_cmd", 32'(bus.cmd), 32'h3BF1);
    bus.cmd_rdy_UART = 1'b0;
    accept(1); respond(1);
    for (int i = 1; i < 10; i++) begin
      accept(1); respond(1); accept(1); respond(1);
    end
    accept(1); respond(1); accept(1);
    chk("mid_idx", 32'(mv_indx), 32'd10);
    chk("mid_active", 32'(tour_active), 32'd1);
    done0 = n_done;
    rst_n = 1'b0; bus.cmd_UART = 16'h1234; bus.cmd_rdy_UART = 1'b1; #1;
    chk("mid_rst_active", 32'(tour_active), 32'd0);
    chk("mid_rst_idx", 32'(mv_indx), 32'd0);
    chk("mid_rst_cmd", 32'(bus.cmd), 32'h1234);
    chk("mid_rst_rdy", 32'(bus.cmd_rdy), 32'd1);
    bus.cmd_rdy_UART = 1'b0;
    cyc(2); rst_n = 1'b1;
    acc0 = n_acc;
    respond(1); cyc(20);
    chk("mid_no_done", 32'(n_done - done0), 32'd0);
    chk("mid_no_reissue", 32'(n_acc - acc0), 32'd0);
    chk("mid_sb_empty", 32'(sb_q.size()), 32'd0);

    // Zero move at index 5 aborts after five full moves.
    for (int i = 0; i < 32; i++) tour_mv[i] = 8'h00;
    tour_mv[0] = 8'h80; push_move(0, 7);
    tour_mv[1] = 8'h08; push_move(1, 3);
    tour_mv[2] = 8'h20; push_move(2, 5);
    tour_mv[3] = 8'h01; push_move(3, 0);
    tour_mv[4] = 8'h40; push_move(4, 6);
    acc0 = n_acc;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      accept(2); respond(3); accept(2); respond(3);
    end
    chk("abort_no_rdy", 32'(bus.cmd_rdy), 32'd0);
    wait_err();
    chk("abort_idx", 32'(mv_indx), 32'd5);
    chk("abort_active", 32'(tour_active), 32'd0);
    chk("abort_acc", 32'(n_acc - acc0), 32'd10);
    chk("abort_sb_empty", 32'(sb_q.size()), 32'd0);
    cyc(1);
    chk("abort_err_pulse", 32'(tour_err), 32'd0);
    cyc(2);

    // Full 24-move tour with 3-cycle accept and 20-cycle response latency.
    ex = 0; ey = 0; px = 0; py = 0;
    for (int i = 0; i < 24; i++) begin
      b = $urandom_range(0, 7);
      tour_mv[i] = 8'h01 << b; push_move(i, b);
      ex += dx_t[b]; ey += dy_t[b];
    end
    acc0 = n_acc; done0 = n_done; err0 = n_err;
    pulse_start();
    for (int i = 0; i < 48; i++) begin
      accept(3); respond(20);
    end
    chk("full_done_pulse", 32'(tour_done), 32'd1);
    chk("full_done_inactive", 32'(tour_active), 32'd0);
    chk("full_last_idx", 32'(mv_indx), 32'd23);
    cyc(1);
    chk("full_done_one_cycle", 32'(tour_done), 32'd0);
    cyc(5);
    chk("full_acc", 32'(n_acc - acc0), 32'd48);
    chk("full_done_count", 32'(n_done - done0), 32'd1);
    chk("full_no_err", 32'(n_err - err0), 32'd0);
    chk("full_path_x", 32'(px), 32'(ex));
    chk("full_path_y", 32'(py), 32'(ey));
    chk("full_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tour_cmd_seq.md
# tour_cmd_seq

Tour command sequencer. It sits directly downstream of the tour solver. After the solver's one-cycle completion pulse, it reads the 24 solved moves back one at a time through the solver's index/move readout port. Each one-hot knight move becomes two movement commands, a vertical leg then a horizontal leg, issued to the command processor with a ready/accept/response handshake. While a tour is not running, the block passes UART-sourced commands straight through to the command processor.

## Interface
- No parameters; the board is fixed at 5x5 and a tour is 24 moves.
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_tour` in 1: one-cycle pulse from the solver's done output.
- `move` in 8: one-hot move read from the solver at `mv_indx`.
- `mv_indx` out 5: index of the move being replayed.
- `cmd_UART` in 16: command from the UART wrapper.
- `cmd_rdy_UART` in 1: UART command valid.
- `clr_cmd_rdy_UART` out 1: accept strobe returned to the UART wrapper.
- `cmd` out 16: command to the command processor.
- `cmd_rdy` out 1: `cmd` valid.
- `clr_cmd_rdy` in 1: command processor accepted `cmd`.
- `send_resp` in 1: command processor finished the current command.
- `tour_active` out 1: high whenever the state is not IDLE.
- `tour_done` out 1: one-cycle pulse after the final leg completes.
- `tour_err` out 1: one-cycle pulse when a zero move aborts the tour.

## Operation
- **Move decode.** Each bit of `move` gives (dx, dy):
  - bit0 = (-1, +2), bit1 = (+1, +2)
  - bit2 = (-2, +1), bit3 = (-2, -1)
  - bit4 = (-1, -2), bit5 = (+1, -2)
  - bit6 = (+2, -1), bit7 = (+2, +1)
  - If more than one bit is set, the lowest set bit wins.
- **Command format.** `cmd[15:12]` opcode, `cmd[11:4]` heading, `cmd[3:0]` square count (unsigned).
- **Vertical leg.**
  - Opcode 4'h2 (move).
  - Heading 8'h00 (north) if dy > 0, 8'h7F (south) if dy < 0.
  - Count |dy|.
- **Horizontal leg.**
  - Opcode 4'h3 (move with fanfare).
  - Heading 8'hBF (east) if dx > 0, 8'h3F (west) if dx < 0.
  - Count |dx|.
- **States:** IDLE, VERT, VERT_HOLD, HORZ, HORZ_HOLD.
- **IDLE.**
  - Mux selects the UART path: `cmd` = `cmd_UART`, `cmd_rdy` = `cmd_rdy_UART`, `clr_cmd_rdy_UART` = `clr_cmd_rdy`.
  - `start_tour` sets `mv_indx` to 0 and moves to VERT.
- **All non-IDLE states.**
  - Mux selects the tour path; `clr_cmd_rdy_UART` is held 0.
  - `start_tour` and `cmd_rdy_UART` are ignored.
- **VERT.**
  - `cmd` = vertical leg, `cmd_rdy` = 1.
  - `clr_cmd_rdy` moves to VERT_HOLD.
  - If `move` is 8'h00 on entry, skip the leg: go to IDLE and pulse `tour_err`.
- **VERT_HOLD.**
  - `cmd` is held, `cmd_rdy` = 0.
  - `send_resp` moves to HORZ.
- **HORZ.**
  - `cmd` = horizontal leg, `cmd_rdy` = 1.
  - `clr_cmd_rdy` moves to HORZ_HOLD.
- **HORZ_HOLD.**
  - `cmd_rdy` = 0.
  - On `send_resp` with `mv_indx` = 23: go to IDLE and pulse `tour_done`.
  - On `send_resp` otherwise: increment `mv_indx` and go to VERT.
- **Boundary cases.**
  - `send_resp` in VERT or HORZ (before acceptance) is ignored.
  - If `clr_cmd_rdy` and `send_resp` arrive in the same cycle in VERT or HORZ, only the accept is taken; the response must arrive in the HOLD state.
  - `clr_cmd_rdy` in either HOLD state is ignored.
  - `mv_indx` never wraps: 23 is terminal.
  - Reset mid-tour returns to IDLE immediately; no command is re-issued.

## Timing
- **Reset values:**
  - state IDLE, `mv_indx` 0
  - `tour_active` 0, `tour_done` 0, `tour_err` 0
  - `cmd` and `cmd_rdy` follow the UART inputs, with `clr_cmd_rdy_UART` = `clr_cmd_rdy`
- State, `mv_indx`, `tour_done` and `tour_err` are registered. `cmd`, `cmd_rdy`, `clr_cmd_rdy_UART` and `tour_active` decode combinationally from state and inputs.
- **Latencies:**
  - `start_tour` in cycle N: `cmd_rdy` is high with the move-0 vertical leg in cycle N+1.
  - `clr_cmd_rdy` in cycle N: `cmd_rdy` is low in N+1.
  - `send_resp` in cycle N (VERT_HOLD): the horizontal leg is valid in N+1.
  - `send_resp` in cycle N (HORZ_HOLD): the new `mv_indx` is in N+1, and the next leg decodes from `move` in that same cycle. The solver readout is combinational.
- `tour_done` is high in the cycle after the final `send_resp`; `tour_active` is 0 in that cycle.
- A full tour is exactly 48 `cmd_rdy` assertions.

## Test plan
- **Reset defaults.** Assert reset, drive `cmd_UART` = 16'h2003 with `cmd_rdy_UART` = 1 → `cmd` = 16'h2003, `cmd_rdy` = 1, `tour_active` = 0; pulse `clr_cmd_rdy` → `clr_cmd_rdy_UART` pulses.
- **Single move decode.** Move 0 = 8'h01, pulse `start_tour` → `cmd` = 16'h2002 with `cmd_rdy` = 1; after accept and `send_resp` → `cmd` = 16'h33F1.
- **Full tour.** Responder model with 3-cycle accept latency and 20-cycle response latency → 48 commands; `mv_indx` steps 0..23; exactly one `tour_done` pulse; the decoded legs reconstruct the tour path.
- **Ignored events.** `send_resp` before `clr_cmd_rdy`, plus `start_tour` and `cmd_rdy_UART` mid-tour → no state change, `cmd` unchanged.
- **Zero move abort.** Move 5 = 8'h00 → `tour_err` pulses, state returns to IDLE, and no command is issued for index 5.
- **Reset mid-tour.** Assert `rst_n` low in HORZ_HOLD at `mv_indx` = 10 → IDLE, `mv_indx` = 0, UART path restored, no `tour_done`.
